// File: rtl/cpu_bus_pkg.sv
// Shared constants, types and the address decoder for the CPU bus responder.
package cpu_bus_pkg;

  localparam logic [15:0] RAM_END      = 16'h1FFF;
  localparam logic [15:0] PPU_BASE     = 16'h2000;
  localparam logic [15:0] PPU_END      = 16'h3FFF;
  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;

  localparam logic [2:0]  DMA_OAM_REG_DEF = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    RD    = 3'd3,
    WR    = 3'd4
  } dma_state_t;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_PPU  = 2'd1,
    REG_DMA  = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr <= RAM_END) begin
      return REG_RAM;
    end else if ((addr >= PPU_BASE) && (addr <= PPU_END)) begin
      return REG_PPU;
    end else if (addr == OAM_DMA_ADDR) begin
      return REG_DMA;
    end else begin
      return REG_NONE;
    end
  endfunction

endpackage

// File: rtl/cpu_oam_dma.sv
// OAM DMA engine: halts the CPU and copies one 256-byte page into the PPU OAM data register.
module cpu_oam_dma
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RAM_AW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_trig,
  input  logic [7:0]        i_page,
  input  logic [7:0]        i_ram_rdata,
  input  logic [7:0]        i_open_bus,
  output logic              o_rdy,
  output logic              o_ram_rd,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic              o_ppu_wr,
  output logic [7:0]        o_ppu_data
);

  dma_state_t r_state;
  dma_state_t w_next;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_byte;
  logic       r_parity;
  logic       r_align;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_trig) begin
          w_next = HALT;
        end else begin
          w_next = IDLE;
        end
      end
      HALT: begin
        if (r_align) begin
          w_next = ALIGN;
        end else begin
          w_next = RD;
        end
      end
      ALIGN: w_next = RD;
      RD:    w_next = WR;
      WR: begin
        if (r_idx == 8'hFF) begin
          w_next = IDLE;
        end else begin
          w_next = RD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Free-running parity, transfer page/index and the byte in flight.
  // The alignment decision uses the parity of the cycle that wrote $4014.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_byte   <= 8'h00;
      r_align  <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      if ((r_state == IDLE) && i_trig) begin
        r_page  <= i_page;
        r_idx   <= 8'h00;
        r_align <= r_parity;
      end else if (r_state == RD) begin
        r_byte <= (r_page < 8'h20) ? i_ram_rdata : i_open_bus;
      end else if (r_state == WR) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    o_rdy      = (r_state == IDLE);
    o_ram_rd   = (r_state == RD);
    o_ppu_wr   = (r_state == WR);
    o_ppu_data = r_byte;
    o_ram_addr = RAM_AW'({r_page, r_idx});
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: work RAM, PPU register strobes, open bus and optional OAM DMA.
// OAM DMA is built only when CPU_BUS_OAM_DMA_EN is defined.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RAM_AW      = 11,
  parameter logic [2:0]  DMA_OAM_REG = DMA_OAM_REG_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr_out,
  input  logic [7:0]  cpu_data_out,
  input  logic        ren,
  input  logic        wen,
  output logic [7:0]  cpu_data_in,
  output logic        rdy,
  output logic [2:0]  ppu_reg,
  output logic        ppu_wr_en,
  output logic [7:0]  ppu_wr_data,
  output logic        ppu_rd_en,
  input  logic [7:0]  ppu_rd_data
);

  logic [7:0]        r_ram [0:(2**RAM_AW)-1];
  logic [7:0]        r_cpu_data_in;
  logic [7:0]        r_open_bus;
  region_t           w_region;
  logic              w_rdy;
  logic              w_cpu_wr;
  logic              w_cpu_rd;
  logic [7:0]        w_rd_value;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [7:0]        w_ram_rdata;
  logic              w_dma_ram_rd;
  logic [RAM_AW-1:0] w_dma_ram_addr;
  logic              w_dma_ppu_wr;
  logic [7:0]        w_dma_ppu_data;

  assign w_region = decode_region(cpu_addr_out);
  // A simultaneous write wins over the read
  assign w_cpu_wr = w_rdy & ~rst & wen;
  assign w_cpu_rd = w_rdy & ~rst & ren & ~wen;

`ifdef CPU_BUS_OAM_DMA_EN
  logic w_dma_trig;
  assign w_dma_trig = w_cpu_wr & (w_region == REG_DMA);

  cpu_oam_dma #(
    .RAM_AW (RAM_AW)
  ) u_dma (
    .clk         (clk),
    .rst         (rst),
    .i_trig      (w_dma_trig),
    .i_page      (cpu_data_out),
    .i_ram_rdata (w_ram_rdata),
    .i_open_bus  (r_open_bus),
    .o_rdy       (w_rdy),
    .o_ram_rd    (w_dma_ram_rd),
    .o_ram_addr  (w_dma_ram_addr),
    .o_ppu_wr    (w_dma_ppu_wr),
    .o_ppu_data  (w_dma_ppu_data)
  );
`else
  assign w_rdy          = 1'b1;
  assign w_dma_ram_rd   = 1'b0;
  assign w_dma_ram_addr = '0;
  assign w_dma_ppu_wr   = 1'b0;
  assign w_dma_ppu_data = 8'h00;
`endif

  assign w_ram_addr  = w_dma_ram_rd ? w_dma_ram_addr : cpu_addr_out[RAM_AW-1:0];
  assign w_ram_rdata = r_ram[w_ram_addr];

  // Work RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_cpu_wr && (w_region == REG_RAM)) begin
      r_ram[cpu_addr_out[RAM_AW-1:0]] <= cpu_data_out;
    end
  end

  // Read-data source select
  always_comb begin
    case (w_region)
      REG_RAM: w_rd_value = w_ram_rdata;
      REG_PPU: w_rd_value = ppu_rd_data;
      default: w_rd_value = r_open_bus;
    endcase
  end

  // Registered read data and the open-bus latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_data_in <= 8'h00;
      r_open_bus    <= 8'h00;
    end else if (w_cpu_wr) begin
      r_open_bus <= cpu_data_out;
    end else if (w_cpu_rd) begin
      r_cpu_data_in <= w_rd_value;
      r_open_bus    <= w_rd_value;
    end
  end

  // PPU register port; DMA writes bypass the CPU gating
  always_comb begin
    ppu_reg     = cpu_addr_out[2:0];
    ppu_wr_data = cpu_data_out;
    ppu_wr_en   = 1'b0;
    ppu_rd_en   = 1'b0;
    if (w_dma_ppu_wr) begin
      ppu_reg     = DMA_OAM_REG;
      ppu_wr_data = w_dma_ppu_data;
      ppu_wr_en   = 1'b1;
    end else if (w_region == REG_PPU) begin
      ppu_wr_en = w_cpu_wr;
      ppu_rd_en = w_cpu_rd;
    end else begin
      ppu_wr_en = 1'b0;
      ppu_rd_en = 1'b0;
    end
  end

  assign cpu_data_in = r_cpu_data_in;
  assign rdy         = w_rdy;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder with a cycle-indexed reference model.
// DMA scenarios run when CPU_BUS_OAM_DMA_EN is defined; otherwise $4014 is checked as unmapped.
`timescale 1ns/1ps
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  dout = 8'h00;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  ppu_rd_data = 8'h00;
  logic [7:0]  cpu_data_in;
  logic        rdy;
  logic [2:0]  ppu_reg;
  logic        ppu_wr_en;
  logic [7:0]  ppu_wr_data;
  logic        ppu_rd_en;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cpu_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr_out (addr),
    .cpu_data_out (dout),
    .ren          (ren),
    .wen          (wen),
    .cpu_data_in  (cpu_data_in),
    .rdy          (rdy),
    .ppu_reg      (ppu_reg),
    .ppu_wr_en    (ppu_wr_en),
    .ppu_wr_data  (ppu_wr_data),
    .ppu_rd_en    (ppu_rd_en),
    .ppu_rd_data  (ppu_rd_data)
  );

  // Reference model: cycle index since reset, RAM image, open bus, and DMA window
  int         m_cyc = 0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_ob = 8'h00;
  logic [7:0] m_ram [0:2047];
  bit         m_dma_on = 1'b0;
  int         m_dma_k = 0;
  int         m_dma_par = 0;
  logic [7:0] m_dma_page = 8'h00;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_dma(input int c);
    return m_dma_on && (c > m_dma_k) && (c <= m_dma_k + 513 + m_dma_par);
  endfunction

  // Byte number being written to OAM in cycle c, or -1
  function automatic int dma_wr_idx(input int c);
    int off;
    int pre;
    off = c - m_dma_k;
    pre = 1 + m_dma_par;
    if (!in_dma(c) || (off < pre + 2) || (((off - pre) % 2) != 0)) return -1;
    return (off - pre) / 2 - 1;
  endfunction

  function automatic logic [7:0] dma_byte(input int j);
    logic [10:0] a;
    logic [7:0]  jb;
    if (m_dma_page >= 8'h20) return m_dma_page;
    jb = 8'(j);
    a  = {m_dma_page[2:0], jb};
    return m_ram[a];
  endfunction

  function automatic logic [7:0] rd_value(input logic [15:0] a, input logic [7:0] prd);
    if (a <= 16'h1FFF) return m_ram[a[10:0]];
    if (a <= 16'h3FFF) return prd;
    return m_ob;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cyc    <= 0;
      m_data   <= 8'h00;
      m_ob     <= 8'h00;
      m_dma_on <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (!in_dma(m_cyc)) begin
        if (wen) begin
          m_ob <= dout;
          if (addr <= 16'h1FFF) m_ram[addr[10:0]] <= dout;
`ifdef CPU_BUS_OAM_DMA_EN
          if (addr == 16'h4014) begin
            m_dma_on   <= 1'b1;
            m_dma_k    <= m_cyc;
            m_dma_par  <= m_cyc % 2;
            m_dma_page <= dout;
          end
`endif
        end else if (ren) begin
          m_data <= rd_value(addr, ppu_rd_data);
          m_ob   <= rd_value(addr, ppu_rd_data);
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin : cmp
    int         j;
    bit         e_rdy;
    bit         e_wr;
    bit         e_rd;
    logic [2:0] e_reg;
    logic [7:0] e_wd;
    if (chk_en) begin
      e_rdy = !in_dma(m_cyc);
      j     = dma_wr_idx(m_cyc);
      e_wr  = 1'b0;
      e_rd  = 1'b0;
      e_reg = 3'd0;
      e_wd  = 8'h00;
      if (j >= 0) begin
        e_wr  = 1'b1;
        e_reg = 3'd4;
        e_wd  = dma_byte(j);
      end else if (!rst && e_rdy && (addr >= 16'h2000) && (addr <= 16'h3FFF)) begin
        e_wr  = wen;
        e_rd  = ren && !wen;
        e_reg = addr[2:0];
        e_wd  = dout;
      end
      check("rdy", rdy, e_rdy);
      check("cpu_data_in", cpu_data_in, m_data);
      check("ppu_wr_en", ppu_wr_en, e_wr);
      check("ppu_rd_en", ppu_rd_en, e_rd);
      if (e_wr || e_rd) check("ppu_reg", ppu_reg, e_reg);
      if (e_wr) check("ppu_wr_data", ppu_wr_data, e_wd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; dout = d; wen = 1'b1; ren = 1'b0;
    cyc();
    wen = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    addr = a; ren = 1'b1; wen = 1'b0;
    cyc();
    ren = 1'b0;
  endtask

`ifdef CPU_BUS_OAM_DMA_EN
  // Trigger a DMA from page $02 on a cycle of the given parity; optionally reset after cut_at bytes
  task automatic run_dma(input int par, input int cut_at, output int low, output int nwr);
    bit done;
    done = 1'b0;
    low  = 0;
    nwr  = 0;
    if ((m_cyc % 2) != par) cyc();
    cpu_wr(16'h4014, 8'h02);
    for (int t = 0; t < 700; t++) begin
      @(negedge clk);
      if (rdy) begin
        done = 1'b1;
        break;
      end
      low++;
      if (ppu_wr_en) begin
        check("dma_reg", ppu_reg, 4);
        check("dma_data", ppu_wr_data, (nwr ^ 32'h5A) & 32'hFF);
        nwr++;
      end
      @(posedge clk);
      #1;
      if (nwr == cut_at) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL dma_timeout: rdy still low after 700 cycles, required high");
    end
  endtask
`endif

  initial begin
    int low;
    int nwr;
    int cnt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_data", cpu_data_in, 8'h00);
    check("reset_rdy", rdy, 1);
    check("reset_wr_en", ppu_wr_en, 0);
    check("reset_rd_en", ppu_rd_en, 0);

    cpu_wr(16'h0001, 8'h55);
    cpu_rd(16'h0801);
    check("mirror_0801", cpu_data_in, 8'h55);
    cpu_rd(16'h1801);
    check("mirror_1801", cpu_data_in, 8'h55);

    ppu_rd_data = 8'h80;
    addr = 16'h2002; ren = 1'b1;
    #2;
    check("ppu_rd_strobe", ppu_rd_en, 1);
    check("ppu_rd_reg", ppu_reg, 2);
    cyc();
    ren = 1'b0;
    ppu_rd_data = 8'h00;
    check("ppu_rd_value", cpu_data_in, 8'h80);

    addr = 16'h3FF8; dout = 8'h1E; wen = 1'b1;
    #2;
    check("ppu_wr_strobe", ppu_wr_en, 1);
    check("ppu_wr_reg", ppu_reg, 0);
    check("ppu_wr_data", ppu_wr_data, 8'h1E);
    cyc();
    wen = 1'b0;

    ppu_rd_data = 8'h80;
    cpu_rd(16'h2002);
    ppu_rd_data = 8'h11;
    cpu_rd(16'h5000);
    check("open_bus", cpu_data_in, 8'h80);

    addr = 16'h0010; dout = 8'hAA; ren = 1'b1; wen = 1'b1;
    cyc();
    ren = 1'b0; wen = 1'b0;
    check("rw_read_ignored", cpu_data_in, 8'h80);
    cpu_rd(16'h0010);
    check("rw_write_done", cpu_data_in, 8'hAA);

`ifdef CPU_BUS_OAM_DMA_EN
    for (int i = 0; i < 256; i++) cpu_wr(16'h0200 | 16'(i), 8'(i) ^ 8'h5A);
    run_dma(0, -1, low, nwr);
    check("dma_len_even", low, 513);
    check("dma_count_even", nwr, 256);
    repeat (3) cyc();
    run_dma(1, -1, low, nwr);
    check("dma_len_odd", low, 514);
    check("dma_count_odd", nwr, 256);
    repeat (3) cyc();
    run_dma(0, 100, low, nwr);
    check("rst_cut_count", nwr, 100);
    check("rdy_after_rst", rdy, 1);
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ppu_wr_en) cnt++;
      @(posedge clk);
      #1;
    end
    check("no_wr_after_rst", cnt, 0);
    run_dma(1, -1, low, nwr);
    check("restart_len", low, 514);
    check("restart_count", nwr, 256);
`else
    cpu_wr(16'h4014, 8'h3C);
    cnt = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (!rdy || ppu_wr_en || ppu_rd_en) cnt++;
      @(posedge clk);
      #1;
    end
    check("nodma_quiet", cnt, 0);
    cpu_rd(16'h5000);
    check("nodma_open_bus", cpu_data_in, 8'h3C);
`endif

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
